// File: rtl/string_buffer.sv
// rtl/string_buffer.sv - editable character line buffer with cursor and streaming drain
module string_buffer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          i_sclr_n,
  input  logic          i_type,
  input  logic [7:0]    i_asciiex,
  input  logic          i_asciiex_en,
  input  logic          i_ready,
  output logic [7:0]    o_data,
  output logic          o_valid,
  output logic          o_last,
  output logic [7:0]    o_cur_char,
  output logic [AW:0]   o_len,
  output logic [AW:0]   o_cursor,
  output logic          o_full,
  output logic          o_busy,
  output logic          o_err
);

  typedef enum logic {S_EDIT, S_DRAIN} state_t;

  localparam logic [1:0]    C_RIGHT   = 2'd0;
  localparam logic [1:0]    C_DOWN    = 2'd1;
  localparam logic [1:0]    C_LEFT    = 2'd2;
  localparam logic [1:0]    C_BKSP    = 2'd3;
  localparam logic [AW:0]   C_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   C_ONE     = (AW+1)'(1);
  localparam logic [AW-1:0] C_IDX_ONE = AW'(1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_buf     [DEPTH];
  logic [7:0]    w_buf_nxt [DEPTH];
  logic [AW:0]   r_len;
  logic [AW:0]   w_len_nxt;
  logic [AW:0]   r_cursor;
  logic [AW:0]   w_cursor_nxt;
  logic [AW-1:0] r_idx;
  logic [AW-1:0] w_idx_nxt;
  logic          r_err;
  logic          w_err_nxt;

  logic          w_char_ev;
  logic          w_ctl_ev;
  logic [1:0]    w_code;
  logic          w_accept;
  logic          w_last_beat;

  assign w_char_ev   = i_asciiex_en & ~i_type;
  assign w_ctl_ev    = i_asciiex_en & i_type;
  assign w_code      = i_asciiex[1:0];
  assign w_accept    = (r_state == S_DRAIN) & i_ready;
  assign w_last_beat = ({1'b0, r_idx} == (r_len - C_ONE));

  // Next-state decode: editing operations in EDIT, beat handshake in DRAIN
  always_comb begin
    w_state_nxt  = r_state;
    w_buf_nxt    = r_buf;
    w_len_nxt    = r_len;
    w_cursor_nxt = r_cursor;
    w_idx_nxt    = r_idx;
    w_err_nxt    = 1'b0;

    case (r_state)
      S_EDIT: begin
        if (w_char_ev) begin
          if (r_len == C_DEPTH) begin
            w_err_nxt = 1'b1;
          end else begin
            // open a gap at the cursor by moving the tail up one slot
            for (int i = 1; i < DEPTH; i++) begin
              if (((AW+1)'(i) > r_cursor) && ((AW+1)'(i) <= r_len)) begin
                w_buf_nxt[i] = r_buf[i-1];
              end
            end
            w_buf_nxt[r_cursor[AW-1:0]] = i_asciiex;
            w_len_nxt    = r_len + C_ONE;
            w_cursor_nxt = r_cursor + C_ONE;
          end
        end else if (w_ctl_ev) begin
          case (w_code)
            C_RIGHT: begin
              if (r_cursor < r_len) w_cursor_nxt = r_cursor + C_ONE;
              else                  w_err_nxt    = 1'b1;
            end
            C_LEFT: begin
              if (r_cursor != '0) w_cursor_nxt = r_cursor - C_ONE;
              else                w_err_nxt    = 1'b1;
            end
            C_BKSP: begin
              if (r_cursor != '0) begin
                // close the gap left by the character before the cursor
                for (int i = 0; i < DEPTH - 1; i++) begin
                  if (((AW+1)'(i + 1) >= r_cursor) && ((AW+1)'(i + 1) < r_len)) begin
                    w_buf_nxt[i] = r_buf[i+1];
                  end
                end
                w_len_nxt    = r_len - C_ONE;
                w_cursor_nxt = r_cursor - C_ONE;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
            default: begin
              if (r_len != '0) begin
                w_state_nxt = S_DRAIN;
                w_idx_nxt   = '0;
              end else begin
                w_err_nxt = 1'b1;
              end
            end
          endcase
        end
      end

      default: begin
        if (i_asciiex_en) w_err_nxt = 1'b1;
        if (w_accept) begin
          if (w_last_beat) begin
            w_state_nxt  = S_EDIT;
            w_len_nxt    = '0;
            w_cursor_nxt = '0;
            w_idx_nxt    = '0;
          end else begin
            w_idx_nxt = r_idx + C_IDX_ONE;
          end
        end
      end
    endcase
  end

  // Control state register; reset wins over any strobe or handshake
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      r_state  <= S_EDIT;
      r_len    <= '0;
      r_cursor <= '0;
      r_idx    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_len    <= w_len_nxt;
      r_cursor <= w_cursor_nxt;
      r_idx    <= w_idx_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Character storage; contents beyond len are never exposed so no reset is needed
  always_ff @(posedge clk) begin
    if (i_sclr_n) r_buf <= w_buf_nxt;
  end

  assign o_valid    = (r_state == S_DRAIN);
  assign o_busy     = (r_state == S_DRAIN);
  assign o_data     = (r_state == S_DRAIN) ? r_buf[r_idx] : 8'h00;
  assign o_last     = (r_state == S_DRAIN) & w_last_beat;
  assign o_cur_char = (r_cursor < r_len) ? r_buf[r_cursor[AW-1:0]] : 8'h00;
  assign o_len      = r_len;
  assign o_cursor   = r_cursor;
  assign o_full     = (r_len == C_DEPTH);
  assign o_err      = r_err;

endmodule

// File: tb/tb_string_buffer.sv
// tb/tb_string_buffer.sv - directed self-checking bench for string_buffer
module tb_string_buffer;

  logic       clk = 1'b0;
  logic       i_sclr_n;
  logic       i_type;
  logic [7:0] i_asciiex;
  logic       i_asciiex_en;
  logic       i_ready;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_last;
  logic [7:0] o_cur_char;
  logic [4:0] o_len;
  logic [4:0] o_cursor;
  logic       o_full;
  logic       o_busy;
  logic       o_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  string_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .i_sclr_n(i_sclr_n), .i_type(i_type), .i_asciiex(i_asciiex),
    .i_asciiex_en(i_asciiex_en), .i_ready(i_ready), .o_data(o_data),
    .o_valid(o_valid), .o_last(o_last), .o_cur_char(o_cur_char), .o_len(o_len),
    .o_cursor(o_cursor), .o_full(o_full), .o_busy(o_busy), .o_err(o_err)
  );

  // one strobe, called at a falling edge; returns o_err seen after the rising edge
  task automatic ev(input logic t, input logic [7:0] c, output logic err);
    i_type = t; i_asciiex = c; i_asciiex_en = 1'b1;
    @(negedge clk);
    i_asciiex_en = 1'b0;
    err = o_err;
  endtask

  task automatic ctl(input logic [1:0] code, output logic err);
    ev(1'b1, {6'b0, code}, err);
  endtask

  task automatic type_str(input string s);
    logic e;
    for (int i = 0; i < s.len(); i++) ev(1'b0, s[i], e);
  endtask

  task automatic do_reset;
    i_sclr_n = 1'b0;
    @(negedge clk); @(negedge clk);
    i_sclr_n = 1'b1;
  endtask

  task automatic test_reset;
    logic e;
    i_sclr_n = 1'b0; i_type = 1'b0; i_asciiex = 8'h41; i_asciiex_en = 1'b1;
    @(negedge clk); @(negedge clk);
    i_asciiex_en = 1'b0;
    checks++; if (o_len !== 5'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", o_len); end
    checks++; if (o_cursor !== 5'd0) begin errors++; $display("FAIL reset_cursor got %0d exp 0", o_cursor); end
    checks++; if ({o_valid, o_last, o_err, o_busy, o_full} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {o_valid, o_last, o_err, o_busy, o_full}); end
    checks++; if (o_cur_char !== 8'h00) begin errors++; $display("FAIL reset_cur_char got %h exp 00", o_cur_char); end
    i_sclr_n = 1'b1;
    @(negedge clk);
    checks++; if (o_len !== 5'd0) begin errors++; $display("FAIL reset_strobe_ignored got len %0d exp 0", o_len); end
    ctl(2'd1, e);
    checks++; if (e !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL empty_down got err %b busy %b exp 1 0", e, o_busy); end
    @(negedge clk);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", o_err); end
  endtask

  task automatic test_edit;
    logic e;
    type_str("ABC");
    checks++; if (o_len !== 5'd3 || o_cursor !== 5'd3) begin errors++; $display("FAIL edit_len_cursor got %0d/%0d exp 3/3", o_len, o_cursor); end
    checks++; if (o_cur_char !== 8'h00) begin errors++; $display("FAIL edit_cur_end got %h exp 00", o_cur_char); end
    ctl(2'd2, e); ctl(2'd2, e);
    checks++; if (o_cursor !== 5'd1 || o_cur_char !== 8'h42) begin errors++; $display("FAIL edit_left got cursor %0d char %h exp 1 42", o_cursor, o_cur_char); end
  endtask

  task automatic test_insert;
    logic e;
    string s1 = "AXBC";
    string s2 = "ABC";
    type_str("X");
    checks++; if (o_len !== 5'd4 || o_cursor !== 5'd2 || o_cur_char !== 8'h42) begin errors++; $display("FAIL insert_state got len %0d cur %0d char %h exp 4 2 42", o_len, o_cursor, o_cur_char); end
    ctl(2'd2, e); ctl(2'd2, e);
    for (int i = 0; i < 4; i++) begin
      checks++; if (o_cur_char !== s1[i]) begin errors++; $display("FAIL insert_content[%0d] got %h exp %h", i, o_cur_char, s1[i]); end
      ctl(2'd0, e);
    end
    ctl(2'd2, e); ctl(2'd2, e);
    ctl(2'd3, e);
    checks++; if (e !== 1'b0 || o_len !== 5'd3 || o_cursor !== 5'd1 || o_cur_char !== 8'h42) begin errors++; $display("FAIL bksp_state got err %b len %0d cur %0d char %h exp 0 3 1 42", e, o_len, o_cursor, o_cur_char); end
    ctl(2'd2, e);
    for (int i = 0; i < 3; i++) begin
      checks++; if (o_cur_char !== s2[i]) begin errors++; $display("FAIL bksp_content[%0d] got %h exp %h", i, o_cur_char, s2[i]); end
      ctl(2'd0, e);
    end
  endtask

  task automatic test_drain;
    logic e;
    logic [3:0] pat = 4'b1101;
    string exp = "ABC";
    int nb = 0;
    logic holding = 1'b0;
    logic [7:0] held = 8'h00;
    i_ready = 1'b0;
    ctl(2'd1, e);
    checks++; if (e !== 1'b0 || o_valid !== 1'b1 || o_busy !== 1'b1) begin errors++; $display("FAIL drain_start got err %b valid %b busy %b exp 0 1 1", e, o_valid, o_busy); end
    for (int k = 0; k < 20 && nb < 3; k++) begin
      i_ready = (k < 4) ? pat[3-k] : 1'b1;
      if (holding) begin
        checks++; if (o_valid !== 1'b1 || o_data !== held) begin errors++; $display("FAIL drain_hold got valid %b data %h exp 1 %h", o_valid, o_data, held); end
      end
      if (o_valid && i_ready) begin
        checks++; if (o_data !== exp[nb] || o_last !== (nb == 2)) begin errors++; $display("FAIL drain_beat[%0d] got %h last %b exp %h %b", nb, o_data, o_last, exp[nb], nb == 2); end
        nb++;
        holding = 1'b0;
      end else if (o_valid) begin
        held = o_data;
        holding = 1'b1;
      end
      @(negedge clk);
    end
    i_ready = 1'b0;
    checks++; if (nb !== 3) begin errors++; $display("FAIL drain_count got %0d exp 3", nb); end
    checks++; if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_len !== 5'd0 || o_cursor !== 5'd0) begin errors++; $display("FAIL drain_end got valid %b busy %b len %0d cur %0d exp 0 0 0 0", o_valid, o_busy, o_len, o_cursor); end
  endtask

  task automatic test_full;
    logic e;
    logic any = 1'b0;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      ev(1'b0, 8'(8'h61 + i), e);
      any |= e;
    end
    checks++; if (any !== 1'b0 || o_full !== 1'b1 || o_len !== 5'd16) begin errors++; $display("FAIL fill got err %b full %b len %0d exp 0 1 16", any, o_full, o_len); end
    ev(1'b0, 8'h7a, e);
    checks++; if (e !== 1'b1 || o_len !== 5'd16) begin errors++; $display("FAIL overflow got err %b len %0d exp 1 16", e, o_len); end
    @(negedge clk);
    checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL overflow_pulse got %b exp 0", o_err); end
    ctl(2'd0, e);
    checks++; if (e !== 1'b1 || o_cursor !== 5'd16) begin errors++; $display("FAIL right_at_end got err %b cur %0d exp 1 16", e, o_cursor); end
    for (int i = 0; i < 16; i++) ctl(2'd2, e);
    checks++; if (o_cursor !== 5'd0 || o_cur_char !== 8'h61) begin errors++; $display("FAIL home got cur %0d char %h exp 0 61", o_cursor, o_cur_char); end
    ctl(2'd2, e);
    checks++; if (e !== 1'b1 || o_cursor !== 5'd0) begin errors++; $display("FAIL left_at_0 got err %b cur %0d exp 1 0", e, o_cursor); end
    ctl(2'd3, e);
    checks++; if (e !== 1'b1 || o_len !== 5'd16 || o_cursor !== 5'd0) begin errors++; $display("FAIL bksp_at_0 got err %b len %0d cur %0d exp 1 16 0", e, o_len, o_cursor); end
  endtask

  task automatic test_drain_reject;
    logic e;
    int nb = 0;
    i_ready = 1'b0;
    ctl(2'd1, e);
    ev(1'b0, 8'h71, e);
    checks++; if (e !== 1'b1 || o_valid !== 1'b1 || o_data !== 8'h61 || o_len !== 5'd16) begin errors++; $display("FAIL drain_reject got err %b valid %b data %h len %0d exp 1 1 61 16", e, o_valid, o_data, o_len); end
    i_ready = 1'b1;
    for (int k = 0; k < 40 && nb < 16; k++) begin
      if (o_valid) begin
        checks++; if (o_data !== 8'(8'h61 + nb) || o_last !== (nb == 15)) begin errors++; $display("FAIL full_beat[%0d] got %h last %b exp %h %b", nb, o_data, o_last, 8'(8'h61 + nb), nb == 15); end
        nb++;
      end
      @(negedge clk);
    end
    i_ready = 1'b0;
    checks++; if (nb !== 16 || o_valid !== 1'b0 || o_len !== 5'd0 || o_full !== 1'b0) begin errors++; $display("FAIL full_drain_end got beats %0d valid %b len %0d full %b exp 16 0 0 0", nb, o_valid, o_len, o_full); end
  endtask

  task automatic test_reset_abort;
    logic e;
    i_ready = 1'b0;
    type_str("abcde");
    ctl(2'd1, e);
    i_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h63) begin errors++; $display("FAIL abort_pre got valid %b data %h exp 1 63", o_valid, o_data); end
    i_sclr_n = 1'b0; i_type = 1'b0; i_asciiex = 8'h77; i_asciiex_en = 1'b1;
    @(negedge clk);
    i_asciiex_en = 1'b0;
    checks++; if (o_valid !== 1'b0 || o_len !== 5'd0 || o_busy !== 1'b0 || o_last !== 1'b0 || o_err !== 1'b0) begin errors++; $display("FAIL abort_reset got valid %b len %0d busy %b last %b err %b exp 0 0 0 0 0", o_valid, o_len, o_busy, o_last, o_err); end
    i_sclr_n = 1'b1;
    @(negedge clk);
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL abort_no_beats got valid %b exp 0", o_valid); end
    type_str("Z");
    ctl(2'd1, e);
    checks++; if (o_valid !== 1'b1 || o_data !== 8'h5a || o_last !== 1'b1) begin errors++; $display("FAIL z_beat got valid %b data %h last %b exp 1 5a 1", o_valid, o_data, o_last); end
    @(negedge clk);
    checks++; if (o_valid !== 1'b0 || o_len !== 5'd0 || o_busy !== 1'b0) begin errors++; $display("FAIL z_end got valid %b len %0d busy %b exp 0 0 0", o_valid, o_len, o_busy); end
  endtask

  initial begin
    i_sclr_n = 1'b0; i_type = 1'b0; i_asciiex = 8'h00; i_asciiex_en = 1'b0; i_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_edit();
    test_insert();
    test_drain();
    test_full();
    test_drain_reject();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
